seq_frame_scheduler: RTL and testbench

Arbitrated front end for the 4-bit Mealy sequence detector. Two requesters each present a WORD_W-bit word. The block grants one word at a time (round-robin), clears the detector, then shifts the word into it MSB-first as WORD_W/4 back-to-back 4-bit frames. It samples the detector's Mealy `dec` output on the last bit of every frame and returns a per-frame match mask and a match count to the granted requester.

---
 rtl/seq_frame_scheduler.sv | 161 ++++++++++++++++
 tb/tb_seq_frame_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_scheduler.sv
// Round-robin front end that shifts a granted word MSB-first into a 4-bit Mealy
// sequence detector and reports per-frame matches. Optional abort input: SEQ_SCHED_ABORT_EN.
module seq_frame_scheduler #(
  parameter int WORD_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req0,
  input  logic                            req1,
  input  logic [WORD_W-1:0]               data0,
  input  logic [WORD_W-1:0]               data1,
`ifdef SEQ_SCHED_ABORT_EN
  input  logic                            abort,
`endif
  input  logic                            det_dec,
  output logic                            gnt0,
  output logic                            gnt1,
  output logic                            busy,
  output logic                            det_in,
  output logic                            det_rst_n,
  output logic                            done,
  output logic                            done_id,
  output logic [WORD_W/4-1:0]             match_mask,
  output logic [$clog2(WORD_W/4+1)-1:0]   match_cnt
);

  localparam int NF    = WORD_W / 4;
  localparam int CNT_W = $clog2(NF + 1);
  localparam int BC_W  = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              winner_q, winner_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NF-1:0]     wmask_q, wmask_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [NF-1:0]     mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_id_q, done_id_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      winner_q  <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      wmask_q   <= '0;
      wcnt_q    <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      done_id_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      winner_q  <= winner_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      wmask_q   <= wmask_d;
      wcnt_q    <= wcnt_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      done_id_q <= done_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d   = state_q;
    last_d    = last_q;
    winner_d  = winner_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    wmask_d   = wmask_q;
    wcnt_d    = wcnt_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    done_id_d = done_id_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time gets the grant.
          winner_d = (req0 && req1) ? ~last_q : req1;
          last_d   = winner_d;
          shreg_d  = winner_d ? data1 : data0;
          gnt0_d   = ~winner_d;
          gnt1_d   = winner_d;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        wmask_d   = '0;
        wcnt_d    = '0;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        // The detector's dec is only meaningful on the 4th bit of each frame.
        if (bit_cnt_q[1:0] == 2'b11 && det_dec) begin
          wmask_d = wmask_q | (NF'(1) << bit_cnt_q[BC_W-1:2]);
          wcnt_d  = wcnt_q + CNT_W'(1);
        end
        if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
          mask_d    = wmask_d;
          cnt_d     = wcnt_d;
          done_id_d = winner_q;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef SEQ_SCHED_ABORT_EN
    if (abort && (state_q == ST_CLEAR || state_q == ST_SHIFT)) begin
      state_d   = ST_IDLE;
      mask_d    = mask_q;
      cnt_d     = cnt_q;
      done_id_d = done_id_q;
      done_d    = 1'b0;
    end
`endif
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign match_mask = mask_q;
  assign match_cnt  = cnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign det_rst_n  = (state_q == ST_SHIFT);
  assign det_in     = (state_q == ST_SHIFT) && shreg_q[WORD_W-1];

endmodule

// File: tb/tb_seq_frame_scheduler.sv
// Directed bench for seq_frame_scheduler with a behavioural 4-bit frame detector
// that flags the frames 0111, 1100 and 1011.
module tb_seq_frame_scheduler;

  localparam int WORD_W = 16;
  localparam int NF     = 4;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1;
  logic [WORD_W-1:0] data0, data1;
  logic              det_dec;
  logic              gnt0, gnt1, busy, det_in, det_rst_n, done, done_id;
  logic [NF-1:0]     match_mask;
  logic [CW-1:0]     match_cnt;
`ifdef SEQ_SCHED_ABORT_EN
  logic              abort;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_frame_scheduler #(.WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .data0      (data0),
    .data1      (data1),
`ifdef SEQ_SCHED_ABORT_EN
    .abort      (abort),
`endif
    .det_dec    (det_dec),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .busy       (busy),
    .det_in     (det_in),
    .det_rst_n  (det_rst_n),
    .done       (done),
    .done_id    (done_id),
    .match_mask (match_mask),
    .match_cnt  (match_cnt)
  );

  // Detector model: counts bits since reset, Mealy hit on the 4th bit of a frame.
  logic [2:0] dbuf;
  logic [1:0] dcnt;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      dbuf <= '0;
      dcnt <= '0;
    end else begin
      dbuf <= {dbuf[1:0], det_in};
      dcnt <= dcnt + 2'd1;
    end
  end

  function automatic logic pat_hit(input logic [3:0] p);
    return (p == 4'b0111) || (p == 4'b1100) || (p == 4'b1011);
  endfunction

  assign det_dec = det_rst_n && (dcnt == 2'd3) && pat_hit({dbuf, det_in});

  typedef struct {
    logic              req0;
    logic              req1;
    logic [WORD_W-1:0] data0;
    logic [WORD_W-1:0] data1;
    logic              exp_id;
    logic [NF-1:0]     exp_mask;
    logic [CW-1:0]     exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns the number of negedges waited until a grant, or -1 on timeout.
  task automatic wait_gnt(output int n, output logic id);
    n  = -1;
    id = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        n  = i + 1;
        id = gnt1;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic id;
    @(negedge clk);
    req0  = v.req0;
    req1  = v.req1;
    data0 = v.data0;
    data1 = v.data1;
    wait_gnt(n, id);
    req0 = 1'b0;
    req1 = 1'b0;
    check($sformatf("vec%0d_gnt_latency", idx), n, 1);
    check($sformatf("vec%0d_gnt_id", idx), {31'd0, id}, {31'd0, v.exp_id});
    check($sformatf("vec%0d_clear_busy_rstn", idx), {30'd0, busy, det_rst_n}, 32'b10);
    @(negedge clk);
    check($sformatf("vec%0d_gnt_pulse", idx), {30'd0, gnt0, gnt1}, 0);
    wait_done(n);
    check($sformatf("vec%0d_done_latency", idx), n, 16);
    check($sformatf("vec%0d_mask", idx), {28'd0, match_mask}, {28'd0, v.exp_mask});
    check($sformatf("vec%0d_cnt", idx), {29'd0, match_cnt}, {29'd0, v.exp_cnt});
    check($sformatf("vec%0d_done_id", idx), {31'd0, done_id}, {31'd0, v.exp_id});
    @(negedge clk);
    check($sformatf("vec%0d_after_done", idx),
          {26'd0, done, busy, match_mask}, {26'd0, 1'b0, 1'b0, v.exp_mask});
  endtask

  initial begin
    int   n;
    logic id;
    logic seen;

    vecs[0] = '{1'b1, 1'b0, 16'h7CB0, 16'h0000, 1'b0, 4'b0111, 3'd3};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 4'b0000, 3'd0};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 16'h0A50, 1'b1, 4'b0000, 3'd0};
    vecs[3] = '{1'b1, 1'b0, 16'h3B00, 16'h0000, 1'b0, 4'b0010, 3'd1};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'hC7B7, 1'b1, 4'b1111, 3'd4};
    vecs[5] = '{1'b1, 1'b0, 16'hB00C, 16'h0000, 1'b0, 4'b1001, 3'd2};

    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = '0;
    data1 = '0;
`ifdef SEQ_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_ctrl", {26'd0, gnt0, gnt1, busy, det_in, det_rst_n, done}, 0);
    check("reset_result", {24'd0, done_id, match_mask, match_cnt}, 0);
    rst = 1'b0;

    // Tie straight after reset: req0 first, req1 one minimum spacing later.
    @(negedge clk);
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 16'h7CB0;
    data1 = 16'hFFFF;
    wait_gnt(n, id);
    req0 = 1'b0;
    check("tie_first_id", {31'd0, id}, 0);
    check("tie_first_latency", n, 1);
    wait_gnt(n, id);
    req1 = 1'b0;
    check("tie_second_id", {31'd0, id}, 1);
    check("tie_second_spacing", n, 19);
    wait_done(n);
    check("tie_second_done_id", {31'd0, done_id}, 1);

    // Both held continuously: grants alternate 0,1,0,1 at minimum spacing.
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(n, id);
      check($sformatf("alt%0d_id", i), {31'd0, id}, i % 2);
      if (i > 0) check($sformatf("alt%0d_spacing", i), n, 19);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(n);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset during SHIFT bit 7: no done, no gnt, outputs back to reset values.
    @(negedge clk);
    req0  = 1'b1;
    data0 = 16'h7CB0;
    wait_gnt(n, id);
    req0 = 1'b0;
    repeat (8) @(negedge clk);
    check("midshift_rstn_high", {31'd0, det_rst_n}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midshift_reset_state", {25'd0, busy, det_rst_n, done, match_mask}, 0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || gnt0 || gnt1) seen = 1'b1;
    end
    check("midshift_no_done_no_gnt", {31'd0, seen}, 0);
    run_vec(vecs[0], 10);

`ifdef SEQ_SCHED_ABORT_EN
    // Abort during SHIFT bit 5 of a req1 word; previous 0111 result is kept.
    @(negedge clk);
    req1  = 1'b1;
    data1 = 16'hC7B7;
    wait_gnt(n, id);
    req1 = 1'b0;
    check("abort_gnt_id", {31'd0, id}, 1);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {30'd0, busy, det_rst_n}, 0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 0);
    check("abort_mask_kept", {28'd0, match_mask}, 32'b0111);
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 16'h3B00;
    wait_gnt(n, id);
    req0 = 1'b0;
    req1 = 1'b0;
    check("abort_next_tie_id", {31'd0, id}, 0);
    wait_done(n);
    check("abort_next_mask", {28'd0, match_mask}, 32'b0010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
